// File: rtl/clk_sel_ctrl_pkg.sv
// Shared constants for the clock-select controller and the 4:1 glitch-free clock mux.
// Both sides must agree on the select width, the source count and the state encodings.
package clk_sel_ctrl_pkg;

    localparam int SEL_W   = 2;
    localparam int NUM_SRC = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_SWITCH = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchroniser with asynchronous active-low reset.
// It is also used by the reset-synchroniser blocks.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    // NOTE: sequential state uses non-blocking assignments so both flops sample the old values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            q_o    <= 1'b0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/clk_sel_ctrl.sv
// Drives the select of the 4:1 glitch-free clock mux after the target oscillator is ready.
// Define CLK_SEL_CTRL_FALLBACK_EN to add automatic fallback to RESET_SEL when the current source dies.
module clk_sel_ctrl
    import clk_sel_ctrl_pkg::*;
#(
    parameter logic [SEL_W-1:0] RESET_SEL     = '0,
    parameter int               READY_TIMEOUT = 1024,
    parameter int               SETTLE_CYCLES = 16,
    parameter int               CNT_W         = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    input  logic [SEL_W-1:0]   req_sel,
    output logic               req_ready,
    input  logic [NUM_SRC-1:0] src_rdy,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic               done,
`ifdef CLK_SEL_CTRL_FALLBACK_EN
    output logic               fallback,
`endif
    output logic               err
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(READY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);

    logic [NUM_SRC-1:0] rdy_s;
    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   tgt_q, tgt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               req_ready_q, req_ready_d;
    logic               accept;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
        sync_2ff u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d_i   (src_rdy[i]),
            .q_o   (rdy_s[i])
        );
    end

    // req_ready_q is only ever high while the FSM sits in IDLE.
    assign accept = req_valid & req_ready_q;

`ifdef CLK_SEL_CTRL_FALLBACK_EN
    logic       fb_cond, fb_trig;
    logic [1:0] fb_cnt_q, fb_cnt_d;
    logic       fallback_q, fallback_d;

    assign fb_cond = (state_q == ST_IDLE) && !rdy_s[sel_q] && (sel_q != RESET_SEL);
    assign fb_trig = fb_cond && (fb_cnt_q == 2'd3);
`endif

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        tgt_d   = tgt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef CLK_SEL_CTRL_FALLBACK_EN
        fb_cnt_d   = fb_cond ? (fb_trig ? 2'd0 : fb_cnt_q + 2'd1) : 2'd0;
        fallback_d = fallback_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tgt_d   = req_sel;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = (req_sel == sel_q) ? ST_FINISH : ST_CHECK;
`ifdef CLK_SEL_CTRL_FALLBACK_EN
                    fallback_d = 1'b0;
                end else if (fb_trig) begin
                    sel_d      = RESET_SEL;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                    fallback_d = 1'b1;
                    state_d    = ST_SWITCH;
`endif
                end
            end
            ST_CHECK: begin
                if (rdy_s[tgt_q]) begin
                    sel_d   = tgt_q;
                    cnt_d   = '0;
                    state_d = ST_SWITCH;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // The mux needs sel frozen for the whole handover, even if the source drops.
            ST_SWITCH: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_FINISH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef CLK_SEL_CTRL_FALLBACK_EN
        // Drop ready one cycle early so a request cannot race the fallback.
        req_ready_d = (state_d == ST_IDLE) && (fb_cnt_d != 2'd3);
`else
        req_ready_d = (state_d == ST_IDLE);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sel_q       <= RESET_SEL;
            tgt_q       <= RESET_SEL;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            tgt_q       <= tgt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
        end
    end

`ifdef CLK_SEL_CTRL_FALLBACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_cnt_q   <= 2'd0;
            fallback_q <= 1'b0;
        end else begin
            fb_cnt_q   <= fb_cnt_d;
            fallback_q <= fallback_d;
        end
    end

    assign fallback = fallback_q;
`endif

    assign sel       = sel_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign req_ready = req_ready_q;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Scoreboard bench for clk_sel_ctrl: requests push expected completions, a monitor checks done/err.
module tb_clk_sel_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [1:0] req_sel;
    logic       req_ready;
    logic [3:0] src_rdy;
    logic [1:0] sel;
    logic       busy;
    logic       done;
    logic       err;
`ifdef CLK_SEL_CTRL_FALLBACK_EN
    logic       fallback;
`endif

    typedef struct {
        logic       is_err;
        logic [1:0] sel;
        int         acc;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    clk_sel_ctrl #(
        .RESET_SEL     (2'd0),
        .READY_TIMEOUT (1024),
        .SETTLE_CYCLES (16),
        .CNT_W         (11)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_sel   (req_sel),
        .req_ready (req_ready),
        .src_rdy   (src_rdy),
        .sel       (sel),
        .busy      (busy),
        .done      (done),
`ifdef CLK_SEL_CTRL_FALLBACK_EN
        .fallback  (fallback),
`endif
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done/err pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && (done || err)) begin
            check("done_err_exclusive", int'(done & err), 0);
            if (sb.size() == 0) begin
                check("spurious_event", int'({done, err}), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("event_kind_err", int'(err), int'(e.is_err));
                check("event_sel", int'(sel), int'(e.sel));
                check("event_latency", cyc - e.acc, e.lat);
                check("ready_after_event", int'(req_ready), 1);
                check("busy_after_event", int'(busy), 0);
            end
        end
    end

    // Waits for req_ready, presents one request and records what must come back.
    task automatic issue(input logic [1:0] s, input logic is_err, input logic [1:0] esel, input int lat);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_before_issue", int'(req_ready), 1);
        req_valid = 1'b1;
        req_sel   = s;
        e.is_err  = is_err;
        e.sel     = esel;
        e.acc     = cyc + 1;
        e.lat     = lat;
        sb.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("completion_within_budget", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_sel   = 2'd0;
        src_rdy   = 4'b1111;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_sel", int'(sel), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_req_ready", int'(req_ready), 0);
        rst_n = 1'b1;
        #1 check("req_ready_before_first_edge", int'(req_ready), 0);
        @(negedge clk);
        check("req_ready_after_release", int'(req_ready), 1);

        // Normal switch to source 2 with a rejected request during SWITCH
        src_rdy = 4'b0100;
        repeat (3) @(negedge clk);
        issue(2'd2, 1'b0, 2'd2, 18);
        @(negedge clk);
        check("busy_after_accept", int'(busy), 1);
        check("sel_held_in_check", int'(sel), 0);
        @(negedge clk);
        check("sel_switched", int'(sel), 2);
        req_valid = 1'b1;
        req_sel   = 2'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("req_ready_low_while_busy", int'(req_ready), 0);
            check("sel_stable_in_switch", int'(sel), 2);
        end
        req_valid = 1'b0;
        wait_idle(40);
        check("sel_after_switch", int'(sel), 2);

        // No-op request for the current source
        issue(2'd2, 1'b0, 2'd2, 1);
        wait_idle(10);
        check("sel_after_noop", int'(sel), 2);

        // Timeout on a source that never reports ready
        issue(2'd3, 1'b1, 2'd2, 1024);
        wait_idle(1100);
        check("sel_after_timeout", int'(sel), 2);

        // Switch to source 1
        src_rdy = 4'b0110;
        repeat (3) @(negedge clk);
        issue(2'd1, 1'b0, 2'd1, 18);
        wait_idle(40);
        check("sel_after_switch_1", int'(sel), 1);

        // Asynchronous reset in the middle of SWITCH
        src_rdy = 4'b1111;
        repeat (3) @(negedge clk);
        issue(2'd3, 1'b0, 2'd3, 18);
        repeat (4) @(negedge clk);
        check("sel_before_midop_reset", int'(sel), 3);
        check("busy_before_midop_reset", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("midop_rst_sel", int'(sel), 0);
        check("midop_rst_busy", int'(busy), 0);
        check("midop_rst_req_ready", int'(req_ready), 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("req_ready_after_midop_reset", int'(req_ready), 1);
        check("sel_after_midop_reset", int'(sel), 0);

        // Switch out of the reset source once more, then idle quietly
        repeat (2) @(negedge clk);
        issue(2'd3, 1'b0, 2'd3, 18);
        wait_idle(40);
        check("sel_after_final_switch", int'(sel), 3);
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
